seq_det_ctrl: RTL



---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_det_ctrl_if.sv | 32 +++
 rtl/seq_det_ctrl_sat_acc.sv | 53 +++++
 rtl/seq_det_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1010 sequence-detector controller.
//   state_t      : controller FSM states (3-bit encoding)
//   WORD_W_DEF   : default bits per serialised word
//   CNT_W_DEF    : default running-total width
//   PATTERN_1010 : the pattern recognised by the attached detector
package seq_det_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  localparam logic [3:0] PATTERN_1010 = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Word handshake between the host side and the detector controller.
//   word_in    : parallel word to serialise
//   word_valid : word_in / keep_state are valid
//   keep_state : 1 = do not clear the detector before this word
//   word_ready : controller can accept a word this cycle
// master = host side, slave = controller side.
interface seq_det_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              keep_state;
  logic              word_ready;

  modport master (
    output word_in,
    output word_valid,
    output keep_state,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    input  keep_state,
    output word_ready
  );

endinterface

// File: rtl/seq_det_ctrl_sat_acc.sv
// Saturating accumulator for the running hit total.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clr          : clear the total on the next edge
//   add_en       : add add_val on the next edge (saturating)
//   add_val      : amount to add
//   total        : current total, sticks at 2^CNT_W-1
// When clr and add_en coincide the clear is applied first, so the
// result is min(add_val, max).
module sat_acc #(
  parameter int CNT_W = 8,
  parameter int ADD_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             add_en,
  input  logic [ADD_W-1:0] add_val,
  output logic [CNT_W-1:0] total
);

  // One extra bit above the wider operand so the carry is never lost,
  // even when a single add can exceed the counter range.
  localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;

  logic [CNT_W-1:0] total_reg;
  logic [CNT_W-1:0] total_next;
  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] max_val;

  always_comb begin
    base       = clr ? '0 : SUM_W'(total_reg);
    sum        = base + SUM_W'(add_val);
    max_val    = SUM_W'({CNT_W{1'b1}});
    total_next = total_reg;
    if (add_en) begin
      total_next = (sum > max_val) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end else if (clr) begin
      total_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      total_reg <= '0;
    end else begin
      total_reg <= total_next;
    end
  end

  assign total = total_reg;

endmodule

// File: rtl/seq_det_ctrl.sv
// Controller that feeds words MSB-first into a serial 1010 Moore detector
// and counts its hits.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   word_bus     : word handshake (slave side)
//   clr_total    : clear the running total
//   det_reset    : one-cycle clear pulse to the detector
//   det_seq      : serial bit to the detector
//   det_hit      : detector output (registered, one cycle behind det_seq)
//   word_hits    : hits for the last completed word
//   total_hits   : saturating running total
//   done         : one-cycle pulse when a word is finished
//   busy         : high whenever the controller is not idle
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  seq_det_ctrl_if.slave                 word_bus,
  input  logic                          clr_total,
  output logic                          det_reset,
  output logic                          det_seq,
  input  logic                          det_hit,
  output logic [$clog2(WORD_W+1)-1:0]   word_hits,
  output logic [CNT_W-1:0]              total_hits,
  output logic                          done,
  output logic                          busy
);

  localparam int HIT_W = $clog2(WORD_W + 1);
  localparam int BC_W  = $clog2(WORD_W);

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] shreg_reg, shreg_next;
  logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic              first_reg, first_next;
  logic [HIT_W-1:0]  hit_acc_reg, hit_acc_next;
  logic [HIT_W-1:0]  word_hits_reg, word_hits_next;
  logic              accept;
  logic              counting;

  assign accept   = (state_reg == ST_IDLE) && word_bus.word_valid;
  // The hit for the last bit only shows up in DRAIN, hence both states.
  assign counting = (state_reg == ST_SHIFT) || (state_reg == ST_DRAIN);

  // Next state and Moore outputs
  always_comb begin
    state_next          = state_reg;
    word_bus.word_ready = 1'b0;
    det_reset           = 1'b0;
    det_seq             = 1'b0;
    done                = 1'b0;
    busy                = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        word_bus.word_ready = 1'b1;
        busy                = 1'b0;
        if (word_bus.word_valid) begin
          // The detector state is unknown after reset, so the first word
          // always clears it even if the host asked to keep state.
          state_next = (word_bus.keep_state && !first_reg) ? ST_SHIFT : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        det_reset  = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        det_seq = shreg_reg[WORD_W-1];
        if (bit_cnt_reg == '0) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    shreg_next     = shreg_reg;
    bit_cnt_next   = bit_cnt_reg;
    first_next     = first_reg;
    hit_acc_next   = hit_acc_reg;
    word_hits_next = word_hits_reg;

    if (accept) begin
      shreg_next   = word_bus.word_in;
      first_next   = 1'b0;
      hit_acc_next = '0;
    end

    if (state_reg == ST_SHIFT) begin
      shreg_next   = {shreg_reg[WORD_W-2:0], 1'b0};
      bit_cnt_next = bit_cnt_reg - 1'b1;
    end else if (state_next == ST_SHIFT) begin
      bit_cnt_next = BC_W'(WORD_W - 1);
    end

    if (counting && det_hit) begin
      hit_acc_next = hit_acc_reg + 1'b1;
    end

    if (state_reg == ST_DONE) begin
      word_hits_next = hit_acc_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      first_reg     <= 1'b1;
      hit_acc_reg   <= '0;
      word_hits_reg <= '0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      bit_cnt_reg   <= bit_cnt_next;
      first_reg     <= first_next;
      hit_acc_reg   <= hit_acc_next;
      word_hits_reg <= word_hits_next;
    end
  end

  assign word_hits = word_hits_reg;

  sat_acc #(
    .CNT_W (CNT_W),
    .ADD_W (HIT_W)
  ) u_total (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr_total),
    .add_en  (state_reg == ST_DONE),
    .add_val (hit_acc_reg),
    .total   (total_hits)
  );

endmodule
